// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 once, C/D rotation per round, registered PC-2 subkeys.
// Optional DES_KEY_DECRYPT_EN adds a decrypt input that emits K16..K1.
module des_key_schedule #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        key_start,
`ifdef DES_KEY_DECRYPT_EN
  input  logic        decrypt,
`endif
  output logic [47:0] key_dat,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [4:0]  key_round,
  output logic        key_last,
  output logic        busy
);

  localparam logic [4:0] LAST = 5'(NUM_ROUNDS);

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t      state;
  logic [27:0] c;
  logic [27:0] d;
  logic [4:0]  cnt;

  // DES bit n maps to vector bit (width - n) on both sides
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++)
      r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++)
      r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  function automatic logic shift_one(input logic [4:0] idx);
    return (idx == 5'd1) || (idx == 5'd2) ||
           (idx == 5'd9) || (idx == 5'd16);
  endfunction

  function automatic logic [27:0] rotl(
    input logic [27:0] h,
    input logic        one
  );
    return one ? {h[26:0], h[27]} : {h[25:0], h[27:26]};
  endfunction

`ifdef DES_KEY_DECRYPT_EN
  function automatic logic [27:0] rotr(
    input logic [27:0] h,
    input logic        one
  );
    return one ? {h[0], h[27:1]} : {h[1:0], h[27:2]};
  endfunction

  logic dec_q;
`endif

  logic [55:0] pc1_k;
  logic [27:0] c_st;
  logic [27:0] d_st;
  logic [27:0] c_nx;
  logic [27:0] d_nx;
  logic        sh_one;

  always_comb begin
    pc1_k  = pc1(key_in);
    c_st   = rotl(pc1_k[55:28], 1'b1);
    d_st   = rotl(pc1_k[27:0], 1'b1);
    sh_one = shift_one(cnt + 5'd1);
    c_nx   = rotl(c, sh_one);
    d_nx   = rotl(d, sh_one);
`ifdef DES_KEY_DECRYPT_EN
    if (decrypt) begin
      c_st = pc1_k[55:28];
      d_st = pc1_k[27:0];
    end
    if (dec_q) begin
      sh_one = shift_one(LAST + 5'd1 - cnt);
      c_nx   = rotr(c, sh_one);
      d_nx   = rotr(d, sh_one);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      c         <= '0;
      d         <= '0;
      cnt       <= '0;
      key_dat   <= '0;
      key_valid <= 1'b0;
      key_round <= '0;
      key_last  <= 1'b0;
      busy      <= 1'b0;
`ifdef DES_KEY_DECRYPT_EN
      dec_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (key_start) begin
            c     <= c_st;
            d     <= d_st;
            cnt   <= 5'd1;
            busy  <= 1'b1;
            state <= RUN;
`ifdef DES_KEY_DECRYPT_EN
            dec_q <= decrypt;
`endif
          end
        end
        RUN: begin
          if (!key_valid || key_ready) begin
            key_dat   <= pc2({c, d});
            key_valid <= 1'b1;
            key_round <= cnt;
            key_last  <= (cnt == LAST);
            c         <= c_nx;
            d         <= d_nx;
            cnt       <= cnt + 5'd1;
            if (cnt == LAST)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (key_valid && key_ready) begin
            key_valid <= 1'b0;
            key_last  <= 1'b0;
            key_round <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: directed DES vectors plus random keys and stalls.
// Subkeys are checked against a bit-level DES key schedule model.
module tb_des_key_schedule;

  localparam int NR = 16;
  localparam logic [63:0] KEY_A = 64'h1334_5779_9BBC_DFF1;
  localparam logic [47:0] K1_A  = 48'h1B02_EFFC_7072;
  localparam logic [47:0] K16_A = 48'hCB3D_8B0E_17F5;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFT_T [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key_in;
  logic        key_start;
  logic [47:0] key_dat;
  logic        key_valid;
  logic        key_ready;
  logic [4:0]  key_round;
  logic        key_last;
  logic        busy;
`ifdef DES_KEY_DECRYPT_EN
  logic        decrypt;
`endif

  int total = 0;
  int bad   = 0;
  logic [47:0] exp_q [NR];
  logic [47:0] first_dat;
  logic [47:0] last_dat;

  des_key_schedule #(.NUM_ROUNDS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_start (key_start),
`ifdef DES_KEY_DECRYPT_EN
    .decrypt   (decrypt),
`endif
    .key_dat   (key_dat),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_round (key_round),
    .key_last  (key_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  // Round r subkey from cumulative left rotation of the 1-based C/D halves
  function automatic logic [47:0] ref_subkey(
    input logic [63:0] key,
    input int          r
  );
    bit kb [65];
    bit c  [29];
    bit d  [29];
    bit cd [57];
    int s;
    logic [47:0] o;
    for (int i = 1; i <= 64; i++) kb[i] = key[64-i];
    for (int i = 1; i <= 28; i++) begin
      c[i] = kb[PC1_T[i-1]];
      d[i] = kb[PC1_T[27+i]];
    end
    s = 0;
    for (int j = 1; j <= r; j++) s += SHIFT_T[j-1];
    for (int i = 1; i <= 28; i++) begin
      cd[i]    = c[((i - 1 + s) % 28) + 1];
      cd[28+i] = d[((i - 1 + s) % 28) + 1];
    end
    o = '0;
    for (int j = 1; j <= 48; j++) o[48-j] = cd[PC2_T[j-1]];
    return o;
  endfunction

  task automatic fill_exp(input logic [63:0] key, input bit dec);
    for (int i = 0; i < NR; i++)
      exp_q[i] = dec ? ref_subkey(key, NR - i) : ref_subkey(key, i + 1);
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [63:0] key, input bit dec);
    key_in    = key;
    key_start = 1'b1;
`ifdef DES_KEY_DECRYPT_EN
    decrypt   = dec;
`endif
    fill_exp(key, dec);
    @(negedge clk);
    key_start = 1'b0;
  endtask

  // Entered on a negedge; accepts all remaining subkeys with random stalls
  task automatic collect(input string tag, input int pct);
    int n;
    int cyc;
    bit r;
    n   = 0;
    cyc = 0;
    while (n < NR && cyc < 600) begin
      r = ($urandom_range(99) >= pct);
      key_ready = r;
      if (key_valid && r) begin
        chk({tag, "_dat"}, key_dat, exp_q[n]);
        chk({tag, "_round"}, key_round, n + 1);
        chk({tag, "_last"}, key_last, (n == NR - 1));
        chk({tag, "_busy"}, busy, 1);
        if (n == 0) first_dat = key_dat;
        last_dat = key_dat;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_count"}, n, NR);
    chk({tag, "_end_valid"}, key_valid, 0);
    chk({tag, "_end_busy"}, busy, 0);
    chk({tag, "_end_round"}, key_round, 0);
    chk({tag, "_end_last"}, key_last, 0);
  endtask

  initial begin
    rst       = 1'b1;
    key_in    = '0;
    key_start = 1'b0;
    key_ready = 1'b0;
`ifdef DES_KEY_DECRYPT_EN
    decrypt   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_dat", key_dat, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_round", key_round, 0);
    chk("rst_last", key_last, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Known vector, ready held high
    key_ready = 1'b1;
    start(KEY_A, 0);
    chk("t1_e0_valid", key_valid, 0);
    chk("t1_e0_busy", busy, 1);
    @(negedge clk);
    chk("t1_k1", key_dat, K1_A);
    chk("t1_k1_round", key_round, 1);
    chk("t1_k1_model", key_dat, exp_q[0]);
    repeat (15) @(negedge clk);
    chk("t1_k16", key_dat, K16_A);
    chk("t1_k16_round", key_round, 16);
    chk("t1_k16_last", key_last, 1);
    chk("t1_k16_busy", busy, 1);
    @(negedge clk);
    chk("t1_done_busy", busy, 0);
    chk("t1_done_valid", key_valid, 0);

    // All-zero and all-one keys
    start(64'h0, 0);
    collect("zero", 0);
    chk("zero_k16", last_dat, 48'h0);
    start({64{1'b1}}, 0);
    collect("ones", 0);
    chk("ones_k1", first_dat, {48{1'b1}});

    // Stall while K1 is presented
    start(KEY_A, 0);
    key_ready = 1'b0;
    @(negedge clk);
    chk("stall_valid", key_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_dat", key_dat, K1_A);
      chk("stall_round", key_round, 1);
    end
    collect("stall", 0);
    chk("stall_k16", last_dat, K16_A);

    // Reset in the middle of a run
    start(KEY_A, 0);
    key_ready = 1'b1;
    for (int i = 0; i < 40 && key_round != 5'd7; i++)
      @(negedge clk);
    chk("mid_round7", key_round, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_valid", key_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_round", key_round, 0);
    repeat (2) @(negedge clk);
    chk("mid_quiet", key_valid, 0);
    start(KEY_A, 0);
    @(negedge clk);
    chk("mid_k1", key_dat, K1_A);
    collect("mid_rest", 0);

    // key_start held high; key_in changes after capture
    key_in    = KEY_A;
    key_start = 1'b1;
    fill_exp(KEY_A, 0);
    @(negedge clk);
    key_in = 64'h0E32_9232_EA6D_0D73;
    collect("held", 25);
    @(negedge clk);
    chk("held_restart_busy", busy, 1);
    chk("held_restart_valid", key_valid, 0);
    key_start = 1'b0;
    fill_exp(64'h0E32_9232_EA6D_0D73, 0);
    collect("held2", 25);

    // Random keys, random back-pressure
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(3)) @(negedge clk);
      start({$urandom, $urandom}, 0);
      collect("rand", $urandom_range(60));
    end

`ifdef DES_KEY_DECRYPT_EN
    start(KEY_A, 1);
    collect("dec", 0);
    chk("dec_first", first_dat, K16_A);
    chk("dec_last", last_dat, K1_A);
    for (int it = 0; it < 3; it++) begin
      start({$urandom, $urandom}, 1);
      collect("dec_rand", 40);
    end
    start(KEY_A, 0);
    collect("enc_after_dec", 20);
    chk("enc_after_dec_k1", first_dat, K1_A);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
